// File: rtl/v60_regmask_seq.sv
// Multi-register transfer sequencer: walks a register mask one register per beat,
// streaming register-file contents out (store) or load data into the register file.
module v60_regmask_seq #(
  parameter int REG_WIDTH = 32,
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 dir,
  input  logic                 order,
  input  logic [NUM_REGS-1:0]  mask,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [5:0]           count,
  output logic [ADDR_W-1:0]    rf_raddr,
  input  logic [REG_WIDTH-1:0] rf_rdata,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [REG_WIDTH-1:0] rf_wdata,
  output logic                 rf_wen,
  output logic                 st_valid,
  input  logic                 st_ready,
  output logic [REG_WIDTH-1:0] st_data,
  output logic [ADDR_W-1:0]    st_idx,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [REG_WIDTH-1:0] ld_data
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    LD_WAIT  = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t                 state_reg;
  logic [NUM_REGS-1:0]    pending_reg;
  logic                   order_reg;
  logic [5:0]             count_reg;
  logic [REG_WIDTH-1:0]   st_data_reg;
  logic [ADDR_W-1:0]      st_idx_reg;

  logic [ADDR_W-1:0]      cur;
  logic [NUM_REGS-1:0]    pending_next;
  logic [5:0]             count_inc;
  logic                   ld_take;

  // Priority pick: the last match in the scan wins, so scan opposite to the wanted end.
  always_comb begin
    cur = '0;
    if (order_reg) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (pending_reg[i]) cur = ADDR_W'(i);
    end else begin
      for (int i = NUM_REGS - 1; i >= 0; i--)
        if (pending_reg[i]) cur = ADDR_W'(i);
    end
  end

  assign pending_next = pending_reg & ~(NUM_REGS'(1) << cur);
  assign count_inc    = (count_reg < 6'(NUM_REGS)) ? count_reg + 6'd1 : count_reg;
  assign ld_take      = (state_reg == LD_WAIT) && ld_valid && !abort;

  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign count    = count_reg;
  assign st_valid = (state_reg == ST_SEND);
  assign st_data  = st_data_reg;
  assign st_idx   = st_idx_reg;
  assign ld_ready = (state_reg == LD_WAIT) && !abort;
  assign rf_raddr = (state_reg == ST_FETCH) ? cur : '0;
  assign rf_wen   = ld_take;
  assign rf_waddr = ld_take ? cur : '0;
  assign rf_wdata = ld_take ? ld_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      order_reg   <= 1'b0;
      count_reg   <= '0;
      st_data_reg <= '0;
      st_idx_reg  <= '0;
    end else if (abort && state_reg != IDLE) begin
      // Completed beats stay counted; the handshake in this cycle is dropped.
      state_reg   <= IDLE;
      pending_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            pending_reg <= mask;
            order_reg   <= order;
            count_reg   <= '0;
            if (mask == '0)
              state_reg <= DONE;
            else if (dir)
              state_reg <= LD_WAIT;
            else
              state_reg <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          st_data_reg <= rf_rdata;
          st_idx_reg  <= cur;
          state_reg   <= ST_SEND;
        end
        ST_SEND: begin
          if (st_ready) begin
            pending_reg <= pending_next;
            count_reg   <= count_inc;
            state_reg   <= (pending_next == '0) ? DONE : ST_FETCH;
          end
        end
        LD_WAIT: begin
          if (ld_valid) begin
            pending_reg <= pending_next;
            count_reg   <= count_inc;
            state_reg   <= (pending_next == '0) ? DONE : LD_WAIT;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_v60_regmask_seq.sv
// Bench for v60_regmask_seq: behavioural register file, beat scoreboard,
// table of transfer operations plus hand-written reset and abort sequences.
module tb_v60_regmask_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        dir;
  logic        order;
  logic [31:0] mask;
  logic        abort;
  logic        busy;
  logic        done;
  logic [5:0]  count;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_wen;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_data;
  logic [4:0]  st_idx;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;

  v60_regmask_seq dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .order(order), .mask(mask),
    .abort(abort), .busy(busy), .done(done), .count(count),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_wen(rf_wen),
    .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data), .st_idx(st_idx),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic        dir;
    logic        order;
    logic [31:0] mask;
    int          hold;      // cycles from start with ready/valid forced low
    int          pct;       // ready/valid probability afterwards
    int          exp_cnt;
    int          exp_done;  // cycle of the done pulse, -1 when timing is random
  } op_t;

  logic [31:0] rf_mem [32];
  assign rf_rdata = rf_mem[rf_raddr];

  beat_t st_q[$];
  beat_t ld_q[$];
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int ld_k = 0;
  int done_cyc = -1;
  int done_total = 0;
  logic last_ld_ready;
  logic last_rf_wen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at the falling edge: outputs are settled and the coming edge will commit them.
  task automatic sample();
    if (st_valid) begin
      if (st_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL st_unexpected: got beat idx %0d data 0x%0h, expected no beat", st_idx, st_data);
      end else begin
        chk("st_idx", 32'(st_idx), 32'(st_q[0].idx));
        chk("st_data", st_data, st_q[0].data);
        if (st_ready) begin
          $display("store beat  idx=%0d data=0x%08h", st_idx, st_data);
          void'(st_q.pop_front());
        end
      end
    end
    if (rf_wen) begin
      if (ld_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL wen_unexpected: got write R%0d=0x%0h, expected no write", rf_waddr, rf_wdata);
      end else begin
        chk("rf_waddr", 32'(rf_waddr), 32'(ld_q[0].idx));
        chk("rf_wdata", rf_wdata, ld_q[0].data);
        chk("wen_needs_valid", 32'(ld_valid), 32'd1);
        $display("load beat   idx=%0d data=0x%08h", rf_waddr, rf_wdata);
        void'(ld_q.pop_front());
      end
      rf_mem[rf_waddr] = rf_wdata;
    end
    if (ld_valid && ld_ready) ld_k++;
    if (done) begin
      done_total++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    last_ld_ready = ld_ready;
    last_rf_wen   = rf_wen;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input op_t t);
    int k;
    int d0;
    bit en;
    k = 0;
    for (int n = 0; n < 32; n++) begin
      int i;
      i = t.order ? 31 - n : n;
      if (t.mask[i]) begin
        if (!t.dir) st_q.push_back('{idx: 5'(i), data: rf_mem[i]});
        else        ld_q.push_back('{idx: 5'(i), data: 32'hA0 + 32'(k)});
        k++;
      end
    end
    d0 = done_total;
    cyc = 0;
    ld_k = 0;
    done_cyc = -1;
    start = 1'b1;
    dir = t.dir;
    order = t.order;
    mask = t.mask;
    while (done_cyc < 0 && cyc < 400) begin
      en = (cyc >= t.hold) && ($urandom_range(99) < 32'(t.pct));
      st_ready = en;
      ld_valid = en;
      ld_data = 32'hA0 + 32'(ld_k);
      tick();
      start = 1'b0;
    end
    st_ready = 1'b0;
    ld_valid = 1'b0;
    tick();
    $display("op dir=%0d order=%0d mask=0x%08h count=%0d done_cycle=%0d",
             t.dir, t.order, t.mask, count, done_cyc);
    chk("count", 32'(count), 32'(t.exp_cnt));
    if (t.exp_done >= 0) chk("done_cycle", 32'(done_cyc), 32'(t.exp_done));
    chk("done_pulses", 32'(done_total - d0), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    chk("st_q_left", 32'(st_q.size()), 32'd0);
    chk("ld_q_left", 32'(ld_q.size()), 32'd0);
  endtask

  op_t ops [9];

  initial begin
    int d0;
    ops[0] = '{dir: 1'b0, order: 1'b0, mask: 32'h0000_0013, hold: 0, pct: 100, exp_cnt: 3,  exp_done: 7};
    ops[1] = '{dir: 1'b0, order: 1'b1, mask: 32'h8000_0001, hold: 5, pct: 100, exp_cnt: 2,  exp_done: 8};
    ops[2] = '{dir: 1'b1, order: 1'b0, mask: 32'h0000_0F00, hold: 0, pct: 50,  exp_cnt: 4,  exp_done: -1};
    ops[3] = '{dir: 1'b0, order: 1'b0, mask: 32'h0000_0000, hold: 0, pct: 100, exp_cnt: 0,  exp_done: 1};
    ops[4] = '{dir: 1'b1, order: 1'b1, mask: 32'hFFFF_FFFF, hold: 0, pct: 100, exp_cnt: 32, exp_done: 33};
    ops[5] = '{dir: 1'b0, order: 1'b0, mask: 32'hFFFF_FFFF, hold: 0, pct: 100, exp_cnt: 32, exp_done: 65};
    ops[6] = '{dir: 1'b1, order: 1'b0, mask: 32'h8000_0001, hold: 0, pct: 100, exp_cnt: 2,  exp_done: 3};
    ops[7] = '{dir: 1'b0, order: 1'b1, mask: 32'h0000_0F0F, hold: 0, pct: 60,  exp_cnt: 8,  exp_done: -1};
    ops[8] = '{dir: 1'b1, order: 1'b0, mask: 32'h0000_0000, hold: 0, pct: 100, exp_cnt: 0,  exp_done: 1};

    for (int i = 0; i < 32; i++) rf_mem[i] = 32'hC000_0000 + 32'(i);
    rf_mem[0]  = 32'h11;
    rf_mem[1]  = 32'h22;
    rf_mem[4]  = 32'h44;
    rf_mem[31] = 32'hDEAD_BEEF;

    // Reset held two cycles with start asserted.
    rst = 1'b1;
    start = 1'b1;
    dir = 1'b0;
    order = 1'b0;
    mask = 32'h0000_0013;
    abort = 1'b0;
    st_ready = 1'b1;
    ld_valid = 1'b0;
    ld_data = '0;
    for (int r = 0; r < 2; r++) begin
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_st_valid", 32'(st_valid), 32'd0);
      chk("rst_ld_ready", 32'(ld_ready), 32'd0);
      chk("rst_rf_wen", 32'(rf_wen), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
    end
    rst = 1'b0;
    start = 1'b0;
    tick();
    chk("idle_after_rst", 32'(busy), 32'd0);

    for (int i = 0; i < 9; i++) begin
      if (i == 1) rf_mem[0] = 32'h5;
      run_op(ops[i]);
    end

    // Abort after two load beats, with start pulses while busy.
    rf_mem[2] = 32'h5EED_0002;
    rf_mem[3] = 32'h5EED_0003;
    ld_q.push_back('{idx: 5'd0, data: 32'hA0});
    ld_q.push_back('{idx: 5'd1, data: 32'hA1});
    d0 = done_total;
    cyc = 0;
    ld_k = 0;
    start = 1'b1;
    dir = 1'b1;
    order = 1'b0;
    mask = 32'h0000_000F;
    ld_valid = 1'b0;
    tick();
    start = 1'b0;
    ld_valid = 1'b1;
    ld_data = 32'hA0;
    tick();
    start = 1'b1;
    ld_data = 32'hA1;
    tick();
    abort = 1'b1;
    ld_data = 32'hA2;
    tick();
    chk("abort_ld_ready", 32'(last_ld_ready), 32'd0);
    chk("abort_rf_wen", 32'(last_rf_wen), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    start = 1'b0;
    abort = 1'b0;
    ld_valid = 1'b0;
    for (int r = 0; r < 3; r++) tick();
    $display("abort count=%0d busy=%0d", count, busy);
    chk("abort_count", 32'(count), 32'd2);
    chk("abort_no_done", 32'(done_total - d0), 32'd0);
    chk("abort_busy_start_ignored", 32'(busy), 32'd0);
    chk("abort_r2", rf_mem[2], 32'h5EED_0002);
    chk("abort_r3", rf_mem[3], 32'h5EED_0003);
    chk("abort_ld_q_left", 32'(ld_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
